// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DMEM arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_WAIT = 2'd1,
      ARB_SEC  = 2'd2
   } arb_state_t;

   localparam logic [31:0] DM_BASE_DEFAULT = 32'h1001_0000;
   localparam int          BYTE_ADDR_W     = 32;
   localparam int          DATA_W          = 32;

   // wait_cnt only ever holds 0 .. max_wait-1
   function automatic int cnt_width(input int max_wait);
      return (max_wait > 1) ? $clog2(max_wait) : 1;
   endfunction

endpackage

// File: rtl/dmem_addr_xlate.sv
// Byte address to DMEM word index; range/alignment check when DMEM_ARB_RANGE_CHK_EN is defined.
module dmem_addr_xlate
   import dmem_arb_pkg::*;
#(
   parameter int          ADDR_W  = 11,
   parameter logic [31:0] DM_BASE = DM_BASE_DEFAULT
) (
   input  logic [BYTE_ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0]      idx,
   output logic                   bad
);

   logic [BYTE_ADDR_W-1:0] offset;
   logic                   unused_offset_bits;

   assign offset             = addr - DM_BASE;
   assign idx                = offset[ADDR_W+1:2];
   assign unused_offset_bits = &{1'b0, offset[BYTE_ADDR_W-1:ADDR_W+2], offset[1:0]};

`ifdef DMEM_ARB_RANGE_CHK_EN
   // One extra bit so the end-of-window bound cannot wrap
   logic [BYTE_ADDR_W:0] limit;

   assign limit = {1'b0, DM_BASE} + ({{BYTE_ADDR_W{1'b0}}, 1'b1} << (ADDR_W + 2));
   assign bad   = (addr < DM_BASE) || ({1'b0, addr} >= limit) || (addr[1:0] != 2'b00);
`else
   assign bad = 1'b0;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port DMEM between the CPU (priority) and a secondary requester.
// Optional sticky address-error port enabled by DMEM_ARB_RANGE_CHK_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int          ADDR_W   = 11,
   parameter logic [31:0] DM_BASE  = DM_BASE_DEFAULT,
   parameter int          MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_ena,
   input  logic              cpu_r,
   input  logic              cpu_w,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   input  logic              sec_req,
   input  logic              sec_we,
   input  logic [31:0]       sec_addr,
   input  logic [31:0]       sec_wdata,
   output logic [31:0]       sec_rdata,
   output logic              sec_ack,
   output logic              dm_ena,
   output logic              dm_r,
   output logic              dm_w,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_data_in,
   input  logic [31:0]       dm_data_out
`ifdef DMEM_ARB_RANGE_CHK_EN
   ,
   output logic              err
`endif
);

   localparam int               CNT_W     = cnt_width(MAX_WAIT);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

   arb_state_t       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             sec_own;
   logic [31:0]      mux_addr;
   logic             addr_bad;
   logic [31:0]      rd_data;

   // sec_own is a registered copy of (state == ARB_SEC) so the grant is glitch-free
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ARB_IDLE;
         wait_cnt <= '0;
         sec_own  <= 1'b0;
      end else begin
         sec_own <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (sec_req) begin
                  wait_cnt <= '0;
                  if (cpu_ena) begin
                     state <= ARB_WAIT;
                  end else begin
                     state   <= ARB_SEC;
                     sec_own <= 1'b1;
                  end
               end
            end
            ARB_WAIT: begin
               if (!sec_req) begin
                  state <= ARB_IDLE;
               end else if (!cpu_ena || wait_cnt == WAIT_LAST) begin
                  state   <= ARB_SEC;
                  sec_own <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ARB_SEC: state <= ARB_IDLE;
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign mux_addr = sec_own ? sec_addr : cpu_addr;

   dmem_addr_xlate #(
      .ADDR_W  (ADDR_W),
      .DM_BASE (DM_BASE)
   ) u_xlate (
      .addr (mux_addr),
      .idx  (dm_addr),
      .bad  (addr_bad)
   );

   // Holding rst_n low gates every strobe, which also aborts a SEC access in flight
   assign dm_ena     = rst_n & (sec_own | cpu_ena);
   assign dm_w       = rst_n & ~addr_bad & (sec_own ? sec_we : cpu_w);
   assign dm_r       = rst_n & (sec_own ? ~sec_we : cpu_r);
   assign dm_data_in = sec_own ? sec_wdata : cpu_wdata;

   assign sec_ack   = rst_n & sec_own;
   assign cpu_stall = rst_n & sec_own & cpu_ena;

   assign rd_data   = addr_bad ? 32'h0 : dm_data_out;
   assign sec_rdata = sec_ack ? rd_data : 32'h0;
   assign cpu_rdata = sec_own ? 32'h0 : rd_data;

`ifdef DMEM_ARB_RANGE_CHK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (dm_ena && addr_bad) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural DMEM and a read-data scoreboard.
module tb_dmem_arbiter;

   localparam int ADDR_W   = 11;
   localparam int MAX_WAIT = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cpu_ena, cpu_r, cpu_w;
   logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
   logic              cpu_stall;
   logic              sec_req, sec_we;
   logic [31:0]       sec_addr, sec_wdata, sec_rdata;
   logic              sec_ack;
   logic              dm_ena, dm_r, dm_w;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_data_in, dm_data_out;
`ifdef DMEM_ARB_RANGE_CHK_EN
   logic              err;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mem [0:(1<<ADDR_W)-1];

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_W   (ADDR_W),
      .DM_BASE  (32'h1001_0000),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cpu_ena     (cpu_ena),
      .cpu_r       (cpu_r),
      .cpu_w       (cpu_w),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_stall   (cpu_stall),
      .sec_req     (sec_req),
      .sec_we      (sec_we),
      .sec_addr    (sec_addr),
      .sec_wdata   (sec_wdata),
      .sec_rdata   (sec_rdata),
      .sec_ack     (sec_ack),
      .dm_ena      (dm_ena),
      .dm_r        (dm_r),
      .dm_w        (dm_w),
      .dm_addr     (dm_addr),
      .dm_data_in  (dm_data_in),
      .dm_data_out (dm_data_out)
`ifdef DMEM_ARB_RANGE_CHK_EN
      ,
      .err         (err)
`endif
   );

   // DMEM: asynchronous read, synchronous write
   always @(posedge clk) begin
      if (dm_ena && dm_w) mem[dm_addr] <= dm_data_in;
   end
   assign dm_data_out = mem[dm_addr];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no end, required $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", nm, act);
      end
   endtask

   task automatic sb_pop(input string nm, input logic [31:0] act);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got 0x%08h required an entry in the empty scoreboard", nm, act);
      end else begin
         check(nm, act, exp_q.pop_front());
      end
   endtask

   task automatic cpu_idle();
      cpu_ena   = 1'b0;
      cpu_r     = 1'b0;
      cpu_w     = 1'b0;
      cpu_addr  = 32'h1001_0000;
      cpu_wdata = 32'h0;
   endtask

   // One CPU access; for reads d is the expected data
   task automatic cpu_op(input logic w, input logic [31:0] addr, input logic [31:0] d, input string nm);
      cpu_ena   = 1'b1;
      cpu_w     = w;
      cpu_r     = ~w;
      cpu_addr  = addr;
      cpu_wdata = w ? d : 32'h0;
      if (!w) exp_q.push_back(d);
      @(negedge clk);
      if (!w) sb_pop(nm, cpu_rdata);
      @(posedge clk);
      #1;
      cpu_idle();
   endtask

   // Full secondary transaction; the CPU optionally reads word 0 every cycle meanwhile
   task automatic sec_op(input logic we, input logic [31:0] addr, input logic [31:0] d,
                         input logic cpu_on, input int exp_lat, input string nm);
      int lat   = 0;
      bit early = 1'b0;
      sec_req   = 1'b1;
      sec_we    = we;
      sec_addr  = addr;
      sec_wdata = we ? d : 32'h0;
      cpu_ena   = cpu_on;
      cpu_r     = cpu_on;
      cpu_w     = 1'b0;
      cpu_addr  = 32'h1001_0000;
      if (!we) exp_q.push_back(d);
      @(negedge clk);
      while (!sec_ack && lat < 40) begin
         if (cpu_stall) early = 1'b1;
         @(negedge clk);
         lat++;
      end
      check({nm, " ack latency"}, 32'(lat), 32'(exp_lat));
      check({nm, " stall before ack"}, 32'(early), 32'd0);
      if (sec_ack) begin
         check({nm, " stall at ack"}, 32'(cpu_stall), 32'(cpu_on));
         if (!we) sb_pop({nm, " sec_rdata"}, sec_rdata);
      end else begin
         exp_q.delete();
      end
      @(posedge clk);
      #1;
      sec_req = 1'b0;
      @(negedge clk);
      check({nm, " ack after"}, 32'(sec_ack), 32'd0);
      check({nm, " stall after"}, 32'(cpu_stall), 32'd0);
      @(posedge clk);
      #1;
      cpu_idle();
   endtask

`ifdef DMEM_ARB_RANGE_CHK_EN
   task automatic cpu_bad_write(input logic [31:0] addr, input string nm);
      cpu_ena   = 1'b1;
      cpu_w     = 1'b1;
      cpu_r     = 1'b0;
      cpu_addr  = addr;
      cpu_wdata = 32'hBAD0_BAD0;
      @(negedge clk);
      check({nm, " dm_w"}, 32'(dm_w), 32'd0);
      @(posedge clk);
      #1;
      cpu_idle();
   endtask
`endif

   typedef struct {
      logic              w;
      logic [31:0]       addr;
      logic [31:0]       data;
      logic [ADDR_W-1:0] exp_idx;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 11'd2};
      vecs[1] = '{1'b0, 32'h1001_0008, 32'hDEAD_BEEF, 11'd2};
      vecs[2] = '{1'b1, 32'h1001_0000, 32'hA5A5_A5A5, 11'd0};
      vecs[3] = '{1'b1, 32'h1001_1FFC, 32'h0BAD_F00D, 11'd2047};
      vecs[4] = '{1'b1, 32'h1001_0004, 32'h1111_1111, 11'd1};
      vecs[5] = '{1'b0, 32'h1001_0000, 32'hA5A5_A5A5, 11'd0};
      vecs[6] = '{1'b0, 32'h1001_1FFC, 32'h0BAD_F00D, 11'd2047};
      vecs[7] = '{1'b0, 32'h1001_0004, 32'h1111_1111, 11'd1};

      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;

      // Reset with every request line asserted: all strobes must stay low
      rst_n     = 1'b0;
      cpu_ena   = 1'b1;
      cpu_r     = 1'b0;
      cpu_w     = 1'b1;
      cpu_addr  = 32'h1001_0008;
      cpu_wdata = 32'hFFFF_FFFF;
      sec_req   = 1'b1;
      sec_we    = 1'b1;
      sec_addr  = 32'h1001_0008;
      sec_wdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset dm_ena", 32'(dm_ena), 32'd0);
      check("reset dm_w", 32'(dm_w), 32'd0);
      check("reset dm_r", 32'(dm_r), 32'd0);
      check("reset sec_ack", 32'(sec_ack), 32'd0);
      check("reset cpu_stall", 32'(cpu_stall), 32'd0);
`ifdef DMEM_ARB_RANGE_CHK_EN
      check("reset err", 32'(err), 32'd0);
`endif
      @(posedge clk);
      #1;
      sec_req = 1'b0;
      cpu_idle();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // CPU-only traffic
      for (int i = 0; i < 8; i++) begin
         cpu_ena   = 1'b1;
         cpu_w     = vecs[i].w;
         cpu_r     = ~vecs[i].w;
         cpu_addr  = vecs[i].addr;
         cpu_wdata = vecs[i].w ? vecs[i].data : 32'h0;
         if (!vecs[i].w) exp_q.push_back(vecs[i].data);
         @(negedge clk);
         check($sformatf("vec%0d dm_addr", i), 32'(dm_addr), 32'(vecs[i].exp_idx));
         check($sformatf("vec%0d dm_w", i), 32'(dm_w), 32'(vecs[i].w));
         check($sformatf("vec%0d cpu_stall", i), 32'(cpu_stall), 32'd0);
         if (!vecs[i].w) sb_pop($sformatf("vec%0d cpu_rdata", i), cpu_rdata);
         @(posedge clk);
         #1;
      end
      cpu_idle();

      // Idle secondary write then read back
      sec_op(1'b1, 32'h1001_0010, 32'h1234_5678, 1'b0, 1, "sec idle write");
      sec_op(1'b0, 32'h1001_0010, 32'h1234_5678, 1'b0, 1, "sec idle read");
      cpu_op(1'b0, 32'h1001_0010, 32'h1234_5678, "cpu read word4");

      // Starvation: CPU busy throughout, forced grant
      sec_op(1'b0, 32'h1001_0008, 32'hDEAD_BEEF, 1'b1, MAX_WAIT + 1, "sec starved read");

      // Collision: CPU write to word 3 while secondary owns DMEM
      cpu_op(1'b1, 32'h1001_000C, 32'h0303_0303, "pre word3");
      sec_req   = 1'b1;
      sec_we    = 1'b1;
      sec_addr  = 32'h1001_0014;
      sec_wdata = 32'hCAFE_0005;
      @(negedge clk);
      check("coll ack early", 32'(sec_ack), 32'd0);
      @(posedge clk);
      #1;
      cpu_ena   = 1'b1;
      cpu_w     = 1'b1;
      cpu_addr  = 32'h1001_000C;
      cpu_wdata = 32'h3333_3333;
      @(negedge clk);
      check("coll sec_ack", 32'(sec_ack), 32'd1);
      check("coll cpu_stall", 32'(cpu_stall), 32'd1);
      check("coll dm_addr", 32'(dm_addr), 32'd5);
      @(posedge clk);
      #1;
      sec_req = 1'b0;
      @(negedge clk);
      check("retry cpu_stall", 32'(cpu_stall), 32'd0);
      check("retry dm_addr", 32'(dm_addr), 32'd3);
      check("stalled write suppressed", cpu_rdata, 32'h0303_0303);
      @(posedge clk);
      #1;
      cpu_idle();
      cpu_op(1'b0, 32'h1001_000C, 32'h3333_3333, "retry committed");
      cpu_op(1'b0, 32'h1001_0014, 32'hCAFE_0005, "coll sec write");

      // Reset in the middle of a secondary write
      cpu_op(1'b1, 32'h1001_0018, 32'h6666_6666, "pre word6");
      sec_req   = 1'b1;
      sec_we    = 1'b1;
      sec_addr  = 32'h1001_0018;
      sec_wdata = 32'h7777_7777;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("rst sec_ack", 32'(sec_ack), 32'd0);
      check("rst dm_w", 32'(dm_w), 32'd0);
      check("rst dm_ena", 32'(dm_ena), 32'd0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      sec_req = 1'b0;
      @(negedge clk);
      check("post rst sec_ack", 32'(sec_ack), 32'd0);
      @(posedge clk);
      #1;
      cpu_op(1'b0, 32'h1001_0018, 32'h6666_6666, "word6 unchanged");
      sec_op(1'b0, 32'h1001_0018, 32'h6666_6666, 1'b0, 1, "post rst idle");

`ifdef DMEM_ARB_RANGE_CHK_EN
      check("err before bad", 32'(err), 32'd0);
      cpu_bad_write(32'h1001_2000, "oob write");
      cpu_bad_write(32'h1001_0002, "misaligned write");
      cpu_op(1'b0, 32'h1001_0002, 32'h0, "misaligned read");
      cpu_op(1'b0, 32'h1001_0000, 32'hA5A5_A5A5, "word0 intact");
      check("err sticky", 32'(err), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("err cleared", 32'(err), 32'd0);
      @(posedge clk);
      #1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
